muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, beside the ALU.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// Signals: iStart/iFunct3/iA/iB/iFlush in, oBusy/oValid/oResult out.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             iStart;
    logic [2:0]       iFunct3;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iFlush;
    logic             oBusy;
    logic             oValid;
    logic [WIDTH-1:0] oResult;

    modport master (
        output iStart, iFunct3, iA, iB, iFlush,
        input  oBusy, oValid, oResult
    );

    modport slave (
        input  iStart, iFunct3, iA, iB, iFlush,
        output oBusy, oValid, oResult
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, sign fix-up in DONE.
// Ports: iCLK, iRST (async active-low), bus (muldiv_unit_if.slave).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         iCLK,
    input  logic         iRST,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG =
        {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_funct3;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_negq;
    logic             r_negr;
    logic [WIDTH-1:0] r_result;

    logic             w_sgn_a;
    logic             w_sgn_b;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic             w_accept;
    logic             w_valid;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_tr;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_fix;

    // Operand signedness by funct3
    always_comb begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
        case (bus.iFunct3)
            3'b010: w_sgn_b = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                w_sgn_a = 1'b0;
                w_sgn_b = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_neg_a = w_sgn_a & bus.iA[WIDTH-1];
    assign w_neg_b = w_sgn_b & bus.iB[WIDTH-1];
    assign w_mag_a = w_neg_a ? -bus.iA : bus.iA;
    assign w_mag_b = w_neg_b ? -bus.iB : bus.iB;

    assign w_div0 = bus.iFunct3[2] & (bus.iB == '0);
    assign w_ovf  = bus.iFunct3[2] & w_sgn_a
                  & (bus.iA == MIN_NEG)
                  & (bus.iB == '1);
    assign w_special = w_div0 | w_ovf;

    assign w_accept = (r_state == S_IDLE)
                    & bus.iStart & ~bus.iFlush;

    // Multiply: {hi,lo} shifts right, lo starts as multiplier
    assign w_mul_sum = r_lo[0] ? (r_hi + {1'b0, r_b}) : r_hi;

    // Divide: {rem,quo} shifts left, trial subtract decides bit
    assign w_div_sh = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_div_tr = w_div_sh - {1'b0, r_b};

    assign w_prod   = {r_hi[WIDTH-1:0], r_lo};
    assign w_prod_s = r_negq ? -w_prod : w_prod;
    assign w_quo_s  = r_negq ? -r_lo : r_lo;
    assign w_rem_s  = r_negr ? -r_hi[WIDTH-1:0]
                             : r_hi[WIDTH-1:0];

    always_comb begin
        w_fix = w_rem_s;
        case (r_funct3)
            3'b000:
                w_fix = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011:
                w_fix = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:
                w_fix = w_quo_s;
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.iFlush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A flush in DONE suppresses the pulse and the result update
    assign w_valid     = (r_state == S_DONE) & ~bus.iFlush;
    assign bus.oBusy   = (r_state != S_IDLE);
    assign bus.oValid  = w_valid;
    assign bus.oResult = w_valid ? w_fix : r_result;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_funct3 <= bus.iFunct3;
                r_b      <= w_mag_b;
                r_cnt    <= CW'(WIDTH);
                r_negq   <= w_neg_a ^ w_neg_b;
                r_negr   <= w_neg_a;
                r_hi     <= '0;
                r_lo     <= w_mag_a;
                // Special results are preloaded unsigned
                if (w_div0) begin
                    r_hi   <= {1'b0, bus.iA};
                    r_lo   <= '1;
                    r_negq <= 1'b0;
                    r_negr <= 1'b0;
                end else if (w_ovf) begin
                    r_lo   <= MIN_NEG;
                    r_negq <= 1'b0;
                    r_negr <= 1'b0;
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_funct3[2]) begin
                    if (!w_div_tr[WIDTH]) begin
                        r_hi <= w_div_tr;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= w_div_sh;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    r_hi <= {1'b0, w_mul_sum[WIDTH:1]};
                    r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                end
            end
            if (w_valid) begin
                r_result <= w_fix;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic reference model.
// Expected busy/valid/result are tracked per cycle from the op schedule.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int busy_lo = 1;
    int busy_hi = 0;
    int valid_cyc = -1;
    logic [31:0] pending = '0;
    logic [31:0] held = '0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_calc(
        input logic [2:0] f,
        input logic [31:0] a,
        input logic [31:0] b);
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        logic [63:0] p;
        int sa;
        int sb;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        xa = (f == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
        xb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
        p = xa * xb;
        r = '0;
        case (f)
            3'b000: r = p[31:0];
            3'b001, 3'b010, 3'b011: r = p[63:32];
            3'b100: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == '1)
                    r = 32'h8000_0000;
                else r = 32'(sa / sb);
            end
            3'b101: begin
                if (b == 0) r = '1;
                else r = a / b;
            end
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == '1)
                    r = '0;
                else r = 32'(sa % sb);
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic bit is_special(
        input logic [2:0] f,
        input logic [31:0] a,
        input logic [31:0] b);
        return f[2] && (b == 0 ||
            (!f[0] && a == 32'h8000_0000 && b == '1));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Per-cycle check, sampled mid-cycle
    always @(negedge clk) begin : cmp
        logic e_valid;
        logic e_busy;
        logic [31:0] e_res;
        if (rst_n && chk_en) begin
            e_busy  = (cyc >= busy_lo) && (cyc <= busy_hi);
            e_valid = (cyc == valid_cyc);
            e_res   = e_valid ? pending : held;
            chk("busy", {31'b0, bus.oBusy}, {31'b0, e_busy});
            chk("valid", {31'b0, bus.oValid}, {31'b0, e_valid});
            chk("result", bus.oResult, e_res);
            if (e_valid) held = pending;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; fo = cycle of flush (0 none), poke = stray start
    task automatic run_op(input logic [2:0] f,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int fo,
                          input bit poke);
        int s;
        int lat;
        lat = is_special(f, a, b) ? 1 : W + 1;
        s = cyc;
        bus.iStart  = 1'b1;
        bus.iFunct3 = f;
        bus.iA      = a;
        bus.iB      = b;
        busy_lo   = s + 1;
        busy_hi   = s + lat;
        valid_cyc = s + lat;
        pending   = ref_calc(f, a, b);
        if (fo >= 1 && fo <= lat) begin
            busy_hi   = s + fo;
            valid_cyc = -1;
        end
        step();
        bus.iStart = 1'b0;
        bus.iA     = $urandom;
        bus.iB     = $urandom;
        for (int k = 1; k <= lat; k++) begin
            bus.iFlush = (k == fo);
            bus.iStart = poke && (k == 5);
            if (bus.iStart) begin
                bus.iFunct3 = 3'($urandom_range(0, 7));
                bus.iA      = $urandom;
                bus.iB      = $urandom;
            end
            step();
            if (k == fo) break;
        end
        bus.iFlush = 1'b0;
        bus.iStart = 1'b0;
    endtask

    initial begin
        bus.iStart  = 1'b0;
        bus.iFunct3 = 3'b000;
        bus.iA      = '0;
        bus.iB      = '0;
        bus.iFlush  = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'b0, bus.oBusy}, 32'd0);
        chk("rst_valid", {31'b0, bus.oValid}, 32'd0);
        chk("rst_result", bus.oResult, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        chk("pin_mul", ref_calc(3'b000, 32'd7, 32'hFFFF_FFFD),
            32'hFFFF_FFEB);
        chk("pin_mulhu", ref_calc(3'b011, '1, '1), 32'hFFFF_FFFE);
        chk("pin_mulh", ref_calc(3'b001, '1, '1), 32'h0);
        chk("pin_mulhsu", ref_calc(3'b010, '1, 32'd2),
            32'hFFFF_FFFF);
        chk("pin_div", ref_calc(3'b100, 32'hFFFF_FFF9, 32'd2),
            32'hFFFF_FFFD);
        chk("pin_rem", ref_calc(3'b110, 32'hFFFF_FFF9, 32'd2),
            32'hFFFF_FFFF);
        chk("pin_divu", ref_calc(3'b101, 32'd100, 32'd7), 32'd14);
        chk("pin_remu", ref_calc(3'b111, 32'd100, 32'd7), 32'd2);
        chk("pin_div0", ref_calc(3'b101, 32'd5, 32'd0), '1);
        chk("pin_rem0", ref_calc(3'b110, 32'd5, 32'd0), 32'd5);
        chk("pin_ovfq", ref_calc(3'b100, 32'h8000_0000, '1),
            32'h8000_0000);
        chk("pin_ovfr", ref_calc(3'b110, 32'h8000_0000, '1), 32'd0);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0);
        run_op(3'b011, '1, '1, 0, 0);
        run_op(3'b001, '1, '1, 0, 0);
        run_op(3'b010, '1, 32'd2, 0, 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'b101, 32'd5, 32'd0, 0, 0);
        run_op(3'b110, 32'd5, 32'd0, 0, 0);
        run_op(3'b100, 32'h8000_0000, '1, 0, 0);
        run_op(3'b110, 32'h8000_0000, '1, 0, 0);
        run_op(3'b111, 32'd100, 32'd7, 0, 0);
        run_op(3'b101, 32'd100, 32'd7, 0, 0);

        // Flush mid-CALC, then immediate restart
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 10, 0);
        run_op(3'b000, 32'd123, 32'd456, 0, 0);

        // Stray start while busy
        run_op(3'b000, 32'h1234, 32'h5678, 0, 1);

        // Flush beats start in IDLE
        bus.iStart = 1'b1;
        bus.iFlush = 1'b1;
        step();
        bus.iStart = 1'b0;
        bus.iFlush = 1'b0;
        step();
        step();

        // Async reset mid-CALC
        run_op(3'b101, 32'd1000, 32'd3, 0, 0);
        busy_lo   = cyc + 1;
        busy_hi   = cyc + W + 1;
        valid_cyc = cyc + W + 1;
        pending   = 32'd30;
        bus.iStart  = 1'b1;
        bus.iFunct3 = 3'b000;
        bus.iA      = 32'd5;
        bus.iB      = 32'd6;
        step();
        bus.iStart = 1'b0;
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, bus.oBusy}, 32'd0);
        chk("mid_rst_valid", {31'b0, bus.oValid}, 32'd0);
        chk("mid_rst_result", bus.oResult, 32'd0);
        busy_lo   = 1;
        busy_hi   = 0;
        valid_cyc = -1;
        held      = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) step();

        for (int i = 0; i < 60; i++) begin
            logic [2:0] f;
            logic [31:0] a;
            logic [31:0] b;
            int lat;
            int fo;
            bit pk;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            lat = is_special(f, a, b) ? 1 : W + 1;
            fo = 0;
            if ($urandom_range(0, 7) == 0)
                fo = $urandom_range(1, lat);
            pk = (fo == 0) && ($urandom_range(0, 3) == 0);
            run_op(f, a, b, fo, pk);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
